jtag_uart_ctrl: RTL and testbench

//  Avalon-MM master that sequences the JTAG_UART slave port for the FP51 core. It turns a byte-stream
//  TX handshake and a byte-stream RX handshake into data/control register accesses.
//  It caches WSPACE so that the control register is not polled per byte, and it schedules RX reads

---
 rtl/jtag_uart_pkg.sv | 36 +++
 rtl/jtag_uart_avm_cycle.sv | 73 +++++++
 rtl/jtag_uart_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_jtag_uart_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_uart_pkg
//  Description : Register map, field positions and FSM encodings shared by
//                the JTAG UART Avalon-MM sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtag_uart_pkg;

  // Slave register offsets
  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  // Field positions inside the data and control registers
  localparam int RVALID_BIT  = 15;
  localparam int RAVAIL_MSB  = 31;
  localparam int RAVAIL_LSB  = 16;
  localparam int WSPACE_MSB  = 31;
  localparam int WSPACE_LSB  = 16;
  localparam int CTRL_RE_BIT = 0;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RD_CTRL = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_RD_DATA = 3'd4
  } state_t;

  typedef enum logic {
    GRANT_TX = 1'b0,
    GRANT_RX = 1'b1
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/jtag_uart_avm_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_uart_avm_cycle
//  Description : Single-command Avalon-MM master. Latches one command on
//                i_start, holds the pins until the slave stops stalling and
//                flags that completing cycle on o_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_uart_avm_cycle
  import jtag_uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_is_write,
  input  logic        i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_active,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_avm_chipselect,
  output logic        o_avm_address,
  output logic        o_avm_read_n,
  output logic        o_avm_write_n,
  output logic [31:0] o_avm_writedata,
  input  logic [31:0] i_avm_readdata,
  input  logic        i_avm_waitrequest
);

  logic        r_cs;
  logic        r_addr;
  logic        r_read_n;
  logic        r_write_n;
  logic [31:0] r_wdata;
  logic        w_done;

  // Completion is the cycle in which the slave accepts the held command
  assign w_done = r_cs & ~i_avm_waitrequest;

  // Hold the command pins stable from launch until completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs      <= 1'b0;
      r_addr    <= ADDR_DATA;
      r_read_n  <= 1'b1;
      r_write_n <= 1'b1;
      r_wdata   <= 32'd0;
    end else if (w_done) begin
      r_cs      <= 1'b0;
      r_read_n  <= 1'b1;
      r_write_n <= 1'b1;
    end else if (i_start && !r_cs) begin
      r_cs      <= 1'b1;
      r_addr    <= i_addr;
      r_read_n  <= i_is_write;
      r_write_n <= ~i_is_write;
      if (i_is_write) begin
        r_wdata <= i_wdata;
      end
    end
  end

  assign o_active         = r_cs;
  assign o_done           = w_done;
  assign o_rdata          = i_avm_readdata;
  assign o_avm_chipselect = r_cs;
  assign o_avm_address    = r_addr;
  assign o_avm_read_n     = r_read_n;
  assign o_avm_write_n    = r_write_n;
  assign o_avm_writedata  = r_wdata;

endmodule
`default_nettype wire

// File: rtl/jtag_uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_uart_ctrl
//  Description : Sequences JTAG UART register accesses for a byte-stream TX
//                and RX handshake. Caches WSPACE, schedules RX reads from
//                irq / RAVAIL / an idle poll timer, round-robins RX and TX.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_uart_ctrl
  import jtag_uart_pkg::*;
#(
  parameter int POLL_CYCLES = 1024,
  parameter int IRQ_RX_EN   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        avm_chipselect,
  output logic        avm_address,
  output logic        avm_read_n,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        irq,
  output logic        busy
);

  localparam int                c_POLL_W   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [c_POLL_W-1:0] c_POLL_MAX = (POLL_CYCLES > 0) ? c_POLL_W'(POLL_CYCLES - 1) : '0;

  state_t              r_state;
  grant_t              r_last_grant;
  logic                r_busy;
  logic                r_tx_ready;
  logic                r_rx_valid;
  logic [7:0]          r_rx_data;
  logic [15:0]         r_wspace;
  logic                r_rx_more;
  logic [c_POLL_W-1:0] r_poll_cnt;

  logic                w_start;
  logic                w_is_write;
  logic                w_addr;
  logic [31:0]         w_wdata;
  logic                w_active;
  logic                w_done;
  logic [31:0]         w_rdata;
  logic                w_poll_hit;
  logic                w_tx_req;
  logic                w_rx_want;
  logic                w_unused_rdata;

  // The timer term vanishes entirely when polling is disabled
  assign w_poll_hit = (POLL_CYCLES != 0) && (r_poll_cnt == c_POLL_MAX);
  // While tx_ready pulses the producer has not yet retired the byte just written
  assign w_tx_req   = tx_valid & ~r_tx_ready;
  assign w_rx_want  = ~r_rx_valid & (irq | r_rx_more | w_poll_hit);

  assign w_unused_rdata = ^w_rdata[RVALID_BIT-1:8];

  // Command presented to the bus holder for the current state
  always_comb begin
    w_start    = 1'b0;
    w_is_write = 1'b0;
    w_addr     = ADDR_DATA;
    w_wdata    = 32'd0;
    case (r_state)
      ST_INIT: begin
        w_start              = ~w_active;
        w_is_write           = 1'b1;
        w_addr               = ADDR_CTRL;
        w_wdata[CTRL_RE_BIT] = (IRQ_RX_EN != 0);
      end
      ST_RD_CTRL: begin
        w_start = ~w_active;
        w_addr  = ADDR_CTRL;
      end
      ST_WR_DATA: begin
        w_start    = ~w_active;
        w_is_write = 1'b1;
        w_wdata    = {24'd0, tx_data};
      end
      ST_RD_DATA: begin
        w_start = ~w_active;
      end
      default: begin
        w_start = 1'b0;
      end
    endcase
  end

  // Main sequencer: arbitration, WSPACE cache, RX buffer and poll timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_INIT;
      r_last_grant <= GRANT_TX;
      r_busy       <= 1'b1;
      r_tx_ready   <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_rx_data    <= 8'd0;
      r_wspace     <= 16'd0;
      r_rx_more    <= 1'b0;
      r_poll_cnt   <= '0;
    end else begin
      r_tx_ready <= 1'b0;
      if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      case (r_state)
        ST_INIT: begin
          if (w_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (r_poll_cnt != c_POLL_MAX) begin
            r_poll_cnt <= r_poll_cnt + 1'b1;
          end
          if (w_rx_want && (!w_tx_req || r_last_grant == GRANT_TX)) begin
            r_state <= ST_RD_DATA;
            r_busy  <= 1'b1;
          end else if (w_tx_req && r_wspace != 16'd0) begin
            r_state <= ST_WR_DATA;
            r_busy  <= 1'b1;
          end else if (w_tx_req) begin
            r_state <= ST_RD_CTRL;
            r_busy  <= 1'b1;
          end else if (w_rx_want) begin
            r_state <= ST_RD_DATA;
            r_busy  <= 1'b1;
          end
        end
        ST_RD_CTRL: begin
          if (w_done) begin
            r_wspace <= w_rdata[WSPACE_MSB:WSPACE_LSB];
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
          end
        end
        ST_WR_DATA: begin
          if (w_done) begin
            r_tx_ready   <= 1'b1;
            r_wspace     <= r_wspace - 16'd1;
            r_last_grant <= GRANT_TX;
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
          end
        end
        ST_RD_DATA: begin
          if (w_done) begin
            r_last_grant <= GRANT_RX;
            r_poll_cnt   <= '0;
            if (w_rdata[RVALID_BIT]) begin
              r_rx_data  <= w_rdata[7:0];
              r_rx_valid <= 1'b1;
            end
            r_rx_more <= (w_rdata[RAVAIL_MSB:RAVAIL_LSB] != 16'd0);
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  jtag_uart_avm_cycle u_avm_cycle (
    .clk               (clk),
    .reset             (reset),
    .i_start           (w_start),
    .i_is_write        (w_is_write),
    .i_addr            (w_addr),
    .i_wdata           (w_wdata),
    .o_active          (w_active),
    .o_done            (w_done),
    .o_rdata           (w_rdata),
    .o_avm_chipselect  (avm_chipselect),
    .o_avm_address     (avm_address),
    .o_avm_read_n      (avm_read_n),
    .o_avm_write_n     (avm_write_n),
    .o_avm_writedata   (avm_writedata),
    .i_avm_readdata    (avm_readdata),
    .i_avm_waitrequest (avm_waitrequest)
  );

  assign tx_ready = r_tx_ready;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_jtag_uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_uart_ctrl
//  Description : Directed self-checking bench for jtag_uart_ctrl. The bench
//                plays the JTAG UART slave by hand, answering each expected
//                bus command in turn.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jtag_uart_ctrl;

  logic        clk             = 1'b0;
  logic        reset           = 1'b1;
  logic        tx_valid        = 1'b0;
  logic [7:0]  tx_data         = 8'h00;
  logic        rx_ready        = 1'b0;
  logic [31:0] avm_readdata    = 32'd0;
  logic        avm_waitrequest = 1'b1;
  logic        irq             = 1'b0;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        avm_chipselect;
  logic        avm_address;
  logic        avm_read_n;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic        busy;

  int checks    = 0;
  int errors    = 0;
  int tx_pulses = 0;
  int cs_cycles = 0;
  int snap;
  int wait_n;

  jtag_uart_ctrl #(
    .POLL_CYCLES (200),
    .IRQ_RX_EN   (1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .tx_valid        (tx_valid),
    .tx_data         (tx_data),
    .tx_ready        (tx_ready),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .rx_ready        (rx_ready),
    .avm_chipselect  (avm_chipselect),
    .avm_address     (avm_address),
    .avm_read_n      (avm_read_n),
    .avm_write_n     (avm_write_n),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .irq             (irq),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Count tx_ready pulses and chipselect cycles as seen at each rising edge
  always @(posedge clk) begin
    if (tx_ready) tx_pulses <= tx_pulses + 1;
    if (avm_chipselect) cs_cycles <= cs_cycles + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for the next bus command, check it, optionally stall, then complete it
  task automatic service(input string tag, input logic wr, input logic adr,
                         input logic [31:0] wd, input logic [31:0] rd, input int stall);
    int n;
    logic [34:0] pins;
    n = 0;
    while (!avm_chipselect && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start"}, 64'(avm_chipselect), 64'd1);
    if (!avm_chipselect) return;
    chk({tag, "_cmd"}, 64'({avm_write_n, avm_read_n, avm_address}), 64'({~wr, wr, adr}));
    if (wr) chk({tag, "_wdata"}, 64'(avm_writedata), 64'(wd));
    pins = {avm_write_n, avm_read_n, avm_address, avm_writedata};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, 64'({avm_chipselect, avm_write_n, avm_read_n, avm_address, avm_writedata}),
          64'({1'b1, pins}));
    end
    avm_readdata    = rd;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    avm_waitrequest = 1'b1;
    avm_readdata    = 32'd0;
    chk({tag, "_end"}, 64'(avm_chipselect), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- 1: reset values, INIT write, then idle
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({avm_chipselect, avm_read_n, avm_write_n, avm_address, avm_writedata,
                           tx_ready, rx_valid, rx_data, busy}),
        64'({1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 1'b1}));
    reset = 1'b0;
    service("init", 1'b1, 1'b1, 32'h0000_0001, 32'd0, 0);
    chk("busy_idle", 64'(busy), 64'd0);

    // ---- 2: WSPACE cache: poll, write, write without poll, poll, write
    tx_data  = 8'h41;
    tx_valid = 1'b1;
    service("t2_rdctrl1", 1'b0, 1'b1, 32'd0, 32'h0002_0000, 0);
    service("t2_wr41", 1'b1, 1'b0, 32'h0000_0041, 32'd0, 0);
    chk("t2_ack41", 64'(tx_ready), 64'd1);
    tx_data = 8'h42;
    service("t2_wr42", 1'b1, 1'b0, 32'h0000_0042, 32'd0, 0);
    chk("t2_ack42", 64'(tx_ready), 64'd1);
    tx_data = 8'h43;
    service("t2_rdctrl2", 1'b0, 1'b1, 32'd0, 32'h0001_0000, 0);
    service("t2_wr43", 1'b1, 1'b0, 32'h0000_0043, 32'd0, 0);
    chk("t2_ack43", 64'(tx_ready), 64'd1);

    // ---- 3: WSPACE=0 three times, then 64; exactly one tx_ready
    tx_data = 8'h44;
    @(negedge clk);
    snap = tx_pulses;
    service("t3_rd0a", 1'b0, 1'b1, 32'd0, 32'h0000_0000, 0);
    service("t3_rd0b", 1'b0, 1'b1, 32'd0, 32'h0000_0000, 0);
    service("t3_rd0c", 1'b0, 1'b1, 32'd0, 32'h0000_0000, 0);
    service("t3_rd64", 1'b0, 1'b1, 32'd0, 32'h0040_0000, 0);
    chk("t3_no_ready_yet", 64'(tx_pulses - snap), 64'd0);
    service("t3_wr44", 1'b1, 1'b0, 32'h0000_0044, 32'd0, 0);
    chk("t3_ack44", 64'(tx_ready), 64'd1);
    tx_valid = 1'b0;
    @(negedge clk);
    chk("t3_one_pulse", 64'({tx_ready, 8'(tx_pulses - snap)}), 64'({1'b0, 8'd1}));

    // ---- 4: irq-driven read with RAVAIL=2, back-pressure, rx_more follow-up
    irq = 1'b1;
    service("t4_rd1", 1'b0, 1'b0, 32'd0, 32'h0002_8055, 0);
    irq = 1'b0;
    chk("t4_rx_byte", 64'({rx_valid, rx_data}), 64'({1'b1, 8'h55}));
    snap = cs_cycles;
    repeat (10) @(negedge clk);
    chk("t4_no_read_full", 64'({rx_valid, 8'(cs_cycles - snap)}), 64'({1'b1, 8'd0}));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("t4_popped", 64'(rx_valid), 64'd0);
    service("t4_rd_more", 1'b0, 1'b0, 32'd0, 32'h0000_0000, 0);
    chk("t4_empty_read", 64'({rx_valid, rx_data}), 64'({1'b0, 8'h55}));
    snap = cs_cycles;
    repeat (10) @(negedge clk);
    chk("t4_more_cleared", 64'(cs_cycles - snap), 64'd0);

    // ---- 5: round robin with 5-cycle stalls on every command
    irq      = 1'b1;
    tx_data  = 8'h50;
    tx_valid = 1'b1;
    service("t5_wr50", 1'b1, 1'b0, 32'h0000_0050, 32'd0, 5);
    chk("t5_ack50", 64'(tx_ready), 64'd1);
    tx_data = 8'h51;
    service("t5_rd_a", 1'b0, 1'b0, 32'd0, 32'h0000_0000, 5);
    service("t5_wr51", 1'b1, 1'b0, 32'h0000_0051, 32'd0, 5);
    chk("t5_ack51", 64'(tx_ready), 64'd1);
    tx_data = 8'h52;
    service("t5_rd_b", 1'b0, 1'b0, 32'd0, 32'h0000_0000, 5);
    service("t5_wr52", 1'b1, 1'b0, 32'h0000_0052, 32'd0, 5);
    chk("t5_ack52", 64'(tx_ready), 64'd1);
    tx_valid = 1'b0;
    irq      = 1'b0;

    // ---- 6: reset during a stalled write
    @(negedge clk);
    snap     = tx_pulses;
    tx_data  = 8'h60;
    tx_valid = 1'b1;
    wait_n   = 0;
    while (!avm_chipselect && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    chk("t6_wr_started", 64'({avm_chipselect, avm_write_n, avm_writedata}),
        64'({1'b1, 1'b0, 32'h0000_0060}));
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_reset", 64'({avm_chipselect, avm_write_n, tx_ready, busy}),
        64'({1'b0, 1'b1, 1'b0, 1'b1}));
    @(negedge clk);
    reset = 1'b0;
    service("t6_init", 1'b1, 1'b1, 32'h0000_0001, 32'd0, 0);
    service("t6_rdctrl", 1'b0, 1'b1, 32'd0, 32'h0004_0000, 0);
    service("t6_wr60", 1'b1, 1'b0, 32'h0000_0060, 32'd0, 0);
    chk("t6_ack60", 64'(tx_ready), 64'd1);
    tx_valid = 1'b0;
    @(negedge clk);
    chk("t6_one_pulse", 64'(tx_pulses - snap), 64'd1);

    // ---- 7: unsolicited poll after about POLL_CYCLES idle cycles
    wait_n = 0;
    while (!avm_chipselect && wait_n < 400) begin
      @(negedge clk);
      wait_n++;
    end
    chk("t7_poll_window", 64'((wait_n >= 150) && (wait_n <= 250)), 64'd1);
    service("t7_poll", 1'b0, 1'b0, 32'd0, 32'h0000_0000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
